// File: rtl/crs_init_sequencer.sv
// Purpose: scripted bus master. It walks a ROM table of WRITE/POLL/DELAY/END entries
//          and drives them onto the system bus through the req/ack handshake.
// Latency: start accepted at edge 0 gives the first req after edge 2. Each access costs
//          the ack round trip plus 3 cycles (ack-low, fetch, decode).
// Backpressure: a request is held with adr/wr_data stable until ack rises. A new request
//          waits for ack low. Each wait is bounded by P_ACK_TIMEOUT.
// Ports:  clk/rst_n (synchronous, active low); start/busy/done/err/err_code/err_ptr for
//         status; rom_adr/rom_data for the table (1-cycle read latency); wr_req/rd_req/
//         bwr_req/ack/adr/wr_data/rd_data for the system bus.
module crs_init_sequencer #(
    parameter int P_ROM_ADR_W   = 8,
    parameter int P_ACK_TIMEOUT = 255,
    parameter int P_POLL_MAX    = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [P_ROM_ADR_W-1:0] err_ptr,
    output logic [P_ROM_ADR_W-1:0] rom_adr,
    input  logic [31:0]            rom_data,
    output logic                   wr_req,
    output logic                   rd_req,
    output logic                   bwr_req,
    input  logic                   ack,
    output logic [11:0]            adr,
    output logic [15:0]            wr_data,
    input  logic [15:0]            rd_data
);

    localparam int TMO_W  = $clog2(P_ACK_TIMEOUT + 1);
    localparam int POLL_W = $clog2(P_POLL_MAX + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(P_ACK_TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(P_POLL_MAX - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam logic [1:0] EC_ACK_TMO  = 2'd1;
    localparam logic [1:0] EC_POLL_TMO = 2'd2;
    localparam logic [1:0] EC_OVERRUN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_REQ,
        S_ACK_LOW,
        S_DELAY
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [15:0]         rd_latch;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [POLL_W-1:0]   poll_cnt;
    logic [15:0]         dly_cnt;

    logic                adv;
    logic                fail;
    logic [1:0]          fail_code;
    logic                unused_rsv;

    // Bits [29:28] of an entry are reserved and carry no meaning.
    assign unused_rsv = ^rom_data[29:28];
    assign bwr_req    = 1'b0;

    // Decide when the current entry is finished (adv) or has failed.
    // wr_data doubles as the POLL expected value.
    always_comb begin
        adv       = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        case (state)
            S_REQ: begin
                if (!ack && tmo_cnt == TMO_LAST) begin
                    fail      = 1'b1;
                    fail_code = EC_ACK_TMO;
                end
            end
            S_ACK_LOW: begin
                if (ack) begin
                    if (tmo_cnt == TMO_LAST) begin
                        fail      = 1'b1;
                        fail_code = EC_ACK_TMO;
                    end
                end else if (op_q == OP_WRITE || rd_latch == wr_data) begin
                    adv = 1'b1;
                end else if (poll_cnt == POLL_LAST) begin
                    fail      = 1'b1;
                    fail_code = EC_POLL_TMO;
                end
            end
            S_DELAY: begin
                if (dly_cnt == 16'd0) begin
                    adv = 1'b1;
                end
            end
            default: ;
        endcase
        // The pointer never wraps: advancing past the last entry means no END was found.
        if (adv && (&rom_adr)) begin
            adv       = 1'b0;
            fail      = 1'b1;
            fail_code = EC_OVERRUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            err_ptr  <= '0;
            rom_adr  <= '0;
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            adr      <= '0;
            wr_data  <= '0;
            op_q     <= OP_WRITE;
            rd_latch <= '0;
            tmo_cnt  <= '0;
            poll_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 2'd0;
                        rom_adr  <= '0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q     <= rom_data[31:30];
                    adr      <= rom_data[27:16];
                    wr_data  <= rom_data[15:0];
                    poll_cnt <= '0;
                    tmo_cnt  <= '0;
                    case (rom_data[31:30])
                        OP_WRITE: begin
                            wr_req <= 1'b1;
                            state  <= S_REQ;
                        end
                        OP_POLL: begin
                            rd_req <= 1'b1;
                            state  <= S_REQ;
                        end
                        OP_DELAY: begin
                            dly_cnt <= rom_data[15:0];
                            state   <= S_DELAY;
                        end
                        default: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    endcase
                end
                S_REQ: begin
                    if (ack) begin
                        wr_req  <= 1'b0;
                        rd_req  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_ACK_LOW;
                        if (op_q == OP_POLL) begin
                            rd_latch <= rd_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ACK_LOW: begin
                    if (ack) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else if (!adv && !fail) begin
                        // POLL mismatch with attempts left: retry the read.
                        poll_cnt <= poll_cnt + 1'b1;
                        rd_req   <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_REQ;
                    end
                end
                S_DELAY: begin
                    if (dly_cnt != 16'd0) begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Entry completion overrides the per-state updates above.
            if (fail) begin
                err      <= 1'b1;
                err_code <= fail_code;
                err_ptr  <= rom_adr;
                busy     <= 1'b0;
                wr_req   <= 1'b0;
                rd_req   <= 1'b0;
                state    <= S_IDLE;
            end else if (adv) begin
                rom_adr <= rom_adr + 1'b1;
                state   <= S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_crs_init_sequencer.sv
// Purpose: self-checking bench for crs_init_sequencer, with a ROM model, a bus responder
//          and an entry-level reference model that predicts the outcome and the bus traffic.
// Latency: one script run per test; the cycle count is predicted from per-entry costs.
// Backpressure: the bus responder acks after a programmable delay, or never.
module tb_crs_init_sequencer;

    localparam int AW       = 3;
    localparam int DEPTH    = 8;
    localparam int POLL_MAX = 4;
    localparam int ACK_TMO  = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_ptr, rom_adr;
    logic [31:0]   rom_data;
    logic          wr_req, rd_req, bwr_req;
    logic          ack = 1'b0;
    logic [11:0]   adr;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data = 16'h0;

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;

    crs_init_sequencer #(
        .P_ROM_ADR_W  (AW),
        .P_ACK_TIMEOUT(ACK_TMO),
        .P_POLL_MAX   (POLL_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_code(err_code),
        .err_ptr (err_ptr),
        .rom_adr (rom_adr),
        .rom_data(rom_data),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .bwr_req (bwr_req),
        .ack     (ack),
        .adr     (adr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Table memory: one-cycle read latency.
    logic [31:0] rom [DEPTH];
    always @(posedge clk) rom_data <= rom[rom_adr];

    // Bus responder: acks ack_lat cycles after seeing req, releases once req drops.
    int          ack_lat   = 0;
    bit          never_ack = 1'b0;
    int          wcnt      = 0;
    logic [15:0] resp_q[$];
    logic [15:0] ref_resp[$];

    always @(posedge clk) begin
        if (!(wr_req || rd_req)) begin
            ack  <= 1'b0;
            wcnt <= 0;
        end else if (!ack && !never_ack) begin
            if (wcnt >= ack_lat) begin
                ack <= 1'b1;
                if (rd_req && resp_q.size() > 0) rd_data <= resp_q.pop_front();
                else if (rd_req) rd_data <= 16'h0;
                else rd_data <= 16'($urandom);
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Completed transfers: {is_read, 3'b0, adr, data}.
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    always @(posedge clk) begin
        if (rst_n && (wr_req || rd_req) && ack)
            got_q.push_back({rd_req, 3'b000, adr, rd_req ? rd_data : wr_data});
    end

    // Handshake rules: no overlapping requests, stable address/data, no req while ack high.
    logic        req_prev = 1'b0;
    logic [11:0] adr_prev = '0;
    logic [15:0] wd_prev  = '0;
    always @(negedge clk) begin
        if (wr_req && rd_req) viol++;
        if ((wr_req || rd_req) && req_prev && (adr != adr_prev || (wr_req && wr_data != wd_prev))) viol++;
        if ((wr_req || rd_req) && !req_prev && ack) viol++;
        if (bwr_req) viol++;
        req_prev = wr_req || rd_req;
        adr_prev = adr;
        wd_prev  = wr_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d);
        return {op, 2'b00, a, d};
    endfunction

    task automatic fill_rom(input logic [31:0] v);
        for (int i = 0; i < DEPTH; i++) rom[i] = v;
    endtask

    function automatic int n_reads();
        int n = 0;
        foreach (got_q[i]) if (got_q[i][31]) n++;
        return n;
    endfunction

    // Entry-level prediction: each entry costs 2 cycles (fetch+decode) plus its body;
    // one bus access with this responder takes ack_lat+4 cycles until ack is seen low.
    task automatic ref_model(input int lat, output bit e_done, output bit e_err,
                             output logic [1:0] e_code, output logic [AW-1:0] e_ptr,
                             output int e_cyc);
        logic [1:0]  op;
        logic [11:0] a;
        logic [15:0] d, v;
        bit          hit;
        e_done = 1'b0; e_err = 1'b0; e_code = 2'd0; e_ptr = '0; e_cyc = 0;
        exp_q.delete();
        for (int pc = 0; pc < DEPTH; pc++) begin
            op = rom[pc][31:30];
            a  = rom[pc][27:16];
            d  = rom[pc][15:0];
            e_cyc += 2;
            if (op == 2'b11) begin
                e_done = 1'b1;
                return;
            end
            if (op == 2'b00) begin
                exp_q.push_back({4'b0000, a, d});
                e_cyc += lat + 4;
            end else if (op == 2'b01) begin
                hit = 1'b0;
                for (int n = 0; n < POLL_MAX && !hit; n++) begin
                    v = (ref_resp.size() > 0) ? ref_resp.pop_front() : 16'h0;
                    exp_q.push_back({4'b1000, a, v});
                    e_cyc += lat + 4;
                    hit = (v == d);
                end
                if (!hit) begin
                    e_err = 1'b1; e_code = 2'd2; e_ptr = AW'(pc);
                    return;
                end
            end else begin
                e_cyc += int'(d) + 1;
            end
        end
        e_err = 1'b1; e_code = 2'd3; e_ptr = AW'(DEPTH - 1);
    endtask

    // Pulse start, then count cycles after the accepting edge until busy falls.
    task automatic run_script(input int budget, input int extra_start, output int first_req,
                              output int end_at, output int req_hi);
        int k;
        first_req = -1; end_at = -1; req_hi = 0;
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        check("accept_busy", busy, 1'b1);
        check("accept_clr", {done, err, err_code}, 4'b0);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
            start = (k == extra_start);
            if (wr_req || rd_req) begin
                req_hi++;
                if (first_req < 0) first_req = k;
            end
        end
        start = 1'b0;
        check("run_ends", busy, 1'b0);
        end_at = k;
    endtask

    task automatic do_test(input string name, input int lat, input int extra,
                           output int first_req, output int req_hi);
        int          end_at, e_cyc;
        bit          e_done, e_err;
        logic [1:0]  e_code;
        logic [AW-1:0] e_ptr;
        ack_lat  = lat;
        ref_resp = resp_q;
        ref_model(lat, e_done, e_err, e_code, e_ptr, e_cyc);
        run_script(3000, extra, first_req, end_at, req_hi);
        check({name, "_done"}, done, e_done);
        check({name, "_err"}, err, e_err);
        check({name, "_code"}, err_code, e_code);
        if (e_err) check({name, "_ptr"}, err_ptr, e_ptr);
        check({name, "_cycles"}, end_at, e_cyc);
        check({name, "_ntrans"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_trans%0d", name, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int fr, rh, ea;
        logic [31:0] e;

        fill_rom(ent(2'b11, 12'h0, 16'h0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {busy, done, err, wr_req, rd_req, bwr_req}, 6'b0);
        check("rst_code", err_code, 2'd0);
        check("rst_ptrs", {err_ptr, rom_adr}, 6'b0);
        rst_n = 1'b1;

        // Single write, ack 3 cycles after req.
        rom[0] = ent(2'b00, 12'h010, 16'hBEEF);
        resp_q.delete();
        do_test("wr", 2, -1, fr, rh);
        check("wr_first_req", fr, 2);
        check("wr_end_state", {done, err, busy}, 3'b100);
        check("wr_bus", got_q.size() > 0 ? got_q[0] : 32'h0, 32'h0010_BEEF);

        // Poll satisfied on the third read.
        rom[0] = ent(2'b01, 12'h020, 16'h0001);
        resp_q = '{16'h0, 16'h0, 16'h1};
        do_test("poll_ok", 1, -1, fr, rh);
        check("poll_ok_reads", n_reads(), 3);
        check("poll_ok_donef", done, 1'b1);

        // Poll never satisfied.
        resp_q.delete();
        do_test("poll_to", 0, -1, fr, rh);
        check("poll_to_reads", n_reads(), POLL_MAX);
        check("poll_to_status", {err, err_code, err_ptr, rd_req}, {1'b1, 2'd2, 3'd0, 1'b0});

        // Write never acked, then a rerun with a live bus.
        rom[0] = ent(2'b00, 12'h033, 16'h1234);
        never_ack = 1'b1;
        run_script(400, -1, fr, ea, rh);
        check("tmo_req_cycles", rh, ACK_TMO);
        check("tmo_end_edge", ea, ACK_TMO + 2);
        check("tmo_status", {err, err_code, err_ptr, wr_req}, {1'b1, 2'd1, 3'd0, 1'b0});
        never_ack = 1'b0;
        do_test("tmo_rerun", 0, -1, fr, rh);
        check("tmo_rerun_err", err, 1'b0);

        // No END entry anywhere.
        fill_rom(ent(2'b10, 12'h0, 16'h0));
        do_test("overrun", 0, -1, fr, rh);
        check("overrun_code", err_code, 2'd3);
        check("overrun_ptr", err_ptr, 3'd7);

        // Delay 5 then END: done after edge 5+2+3.
        fill_rom(ent(2'b11, 12'h0, 16'h0));
        rom[0] = ent(2'b10, 12'h0, 16'd5);
        ack_lat = 0;
        run_script(100, -1, fr, ea, rh);
        check("delay_done_edge", ea, 10);
        check("delay_done", done, 1'b1);

        // Reset while a write is outstanding.
        rom[0] = ent(2'b00, 12'h044, 16'h5555);
        never_ack = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10 && !wr_req; i++) @(negedge clk);
        check("rst_mid_pre", wr_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_flags", {wr_req, rd_req, busy, done, err}, 5'b0);
        check("rst_mid_adr", rom_adr, 3'd0);
        rst_n = 1'b1;
        never_ack = 1'b0;

        // start pulsed in the middle of a delay must not restart the table.
        rom[0] = ent(2'b00, 12'h100, 16'h1111);
        rom[1] = ent(2'b10, 12'h0, 16'd20);
        rom[2] = ent(2'b00, 12'h101, 16'h2222);
        rom[3] = ent(2'b11, 12'h0, 16'h0);
        resp_q.delete();
        do_test("busy_start", 1, 12, fr, rh);

        // Random tables against the reference model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int r = $urandom_range(0, 9);
                if (r <= 2)      e = ent(2'b00, 12'($urandom), 16'($urandom));
                else if (r <= 5) e = ent(2'b01, 12'($urandom), 16'($urandom_range(0, 2)));
                else if (r <= 8) e = ent(2'b10, 12'($urandom), 16'($urandom_range(0, 6)));
                else             e = ent(2'b11, 12'($urandom), 16'($urandom));
                e[29:28] = 2'($urandom_range(0, 3));
                rom[i] = e;
            end
            resp_q.delete();
            for (int i = 0; i < 12; i++) resp_q.push_back(16'($urandom_range(0, 2)));
            do_test($sformatf("rnd%0d", t), $urandom_range(0, 3), -1, fr, rh);
        end

        check("protocol_viol", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
